// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: N-master HREADY grantor, one outstanding NONSEQ per master, fixed-priority or
// round-robin. Define AHB_ARB_TIMEOUT_EN to add the grant watchdog and its timeout_err pulse.
module ahb_master_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [2*NUM_MASTERS-1:0] HTRANS,
  input  logic [NUM_MASTERS-1:0]   slave_done,
  output logic [NUM_MASTERS-1:0]   HREADY,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     timeout_err,
  output logic                     o_dbg_state
);

  localparam logic [1:0] NONSEQ = 2'b10;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_pend, w_pend_nxt;
  logic [NUM_MASTERS-1:0] r_hready, w_hready_nxt;
  logic [IDX_W-1:0]       r_owner, w_owner_nxt;
  logic [IDX_W-1:0]       r_rr_last, w_rr_last_nxt;
  logic [IDX_W-1:0]       w_arb_idx, w_hi_idx, w_lo_idx;
  logic                   w_hi_found;
  logic                   r_timeout;
  logic                   w_owner_done, w_wd_expire, w_release, w_timeout;

  // Handshake: grant_valid high means HREADY holds exactly the owner's bit and grant_idx names it;
  // the grant ends only on the edge that samples slave_done[owner] (or a watchdog expiry).

  always_comb begin
    w_owner_done = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (r_owner == IDX_W'(m)) w_owner_done = slave_done[m];
    end
  end

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;

  // Held at zero while idle, so the first grant cycle always sees a count of zero.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                  r_wd_cnt <= '0;
    else if (r_state == S_GRANT) r_wd_cnt <= r_wd_cnt + 1'b1;
    else                         r_wd_cnt <= '0;
  end

  assign w_wd_expire = (r_state == S_GRANT) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_wd_expire          = 1'b0;
`endif

  // A real completion outranks a coincident watchdog expiry.
  always_comb begin
    w_release = 1'b0;
    w_timeout = 1'b0;
    if (r_state == S_GRANT) begin
      if (w_owner_done) begin
        w_release = 1'b1;
      end else if (w_wd_expire) begin
        w_release = 1'b1;
        w_timeout = 1'b1;
      end
    end
  end

  // Descending scan leaves the lowest matching index; round-robin prefers indices above rr_last.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int m = NUM_MASTERS - 1; m >= 0; m--) begin
      if (r_pend[m]) begin
        if ((ARB_MODE == 1) && (IDX_W'(m) > r_rr_last)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(m);
        end else begin
          w_lo_idx = IDX_W'(m);
        end
      end
    end
    w_arb_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_pend_nxt = r_pend;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (w_release && (r_owner == IDX_W'(m))) w_pend_nxt[m] = 1'b0;
      else if ((HTRANS[2*m +: 2] == NONSEQ) && !r_pend[m]) w_pend_nxt[m] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_hready_nxt  = r_hready;
    w_rr_last_nxt = r_rr_last;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_state_nxt  = S_GRANT;
          w_owner_nxt  = w_arb_idx;
          w_hready_nxt = NUM_MASTERS'(1) << w_arb_idx;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt   = S_IDLE;
          w_owner_nxt   = '0;
          w_hready_nxt  = '0;
          w_rr_last_nxt = r_owner;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_hready  <= '0;
      r_owner   <= '0;
      r_rr_last <= IDX_W'(NUM_MASTERS - 1);
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend    <= w_pend_nxt;
      r_hready  <= w_hready_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_timeout <= w_timeout;
    end
  end

  assign HREADY      = r_hready;
  assign grant_valid = (r_state == S_GRANT);
  assign grant_idx   = r_owner;
  assign timeout_err = r_timeout;
  assign o_dbg_state = (r_state == S_GRANT);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: a fixed-priority and a round-robin instance driven side by side,
// directed vector table, hand-written corner sequences and random traffic against a reference model.
`timescale 1ns/1ps
module tb_ahb_master_arbiter;
  localparam int N   = 3;
  localparam int IW  = $clog2(N);
  localparam int TMO = 8;
`ifdef AHB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           HCLK;
  logic           HRESET;
  logic [2*N-1:0] htrans [2];
  logic [N-1:0]   done   [2];
  logic [N-1:0]   hready [2];
  logic           valid  [2];
  logic [IW-1:0]  idx    [2];
  logic           tmo    [2];
  logic           dbg    [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*N-1:0] htr;
    logic [N-1:0]   dn;
    logic [N-1:0]   hr;
    logic           v;
    logic [IW-1:0]  ix;
  } vec_t;

  vec_t          vecs [18];
  logic [IW-1:0] exp_q [$];

  // reference model state, one set per instance (0 = fixed priority, 1 = round-robin)
  bit m_pend  [2][N];
  bit m_busy  [2];
  int m_owner [2];
  int m_rr    [2];
  int m_wd    [2];
  bit m_tmo   [2];

  ahb_master_arbiter #(.NUM_MASTERS(N), .ARB_MODE(0), .TIMEOUT_CYCLES(TMO)) u_fixed (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(htrans[0]), .slave_done(done[0]),
    .HREADY(hready[0]), .grant_valid(valid[0]), .grant_idx(idx[0]),
    .timeout_err(tmo[0]), .o_dbg_state(dbg[0])
  );

  ahb_master_arbiter #(.NUM_MASTERS(N), .ARB_MODE(1), .TIMEOUT_CYCLES(TMO)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(htrans[1]), .slave_done(done[1]),
    .HREADY(hready[1]), .grant_valid(valid[1]), .grant_idx(idx[1]),
    .timeout_err(tmo[1]), .o_dbg_state(dbg[1])
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      for (int m = 0; m < N; m++) m_pend[md][m] = 1'b0;
      m_busy[md]  = 1'b0;
      m_owner[md] = 0;
      m_rr[md]    = N - 1;
      m_wd[md]    = 0;
      m_tmo[md]   = 1'b0;
    end
  endtask

  // winner among pending masters, walking the priority order for this mode
  function automatic int pick(input int md);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (md == 0) ? i : (m_rr[md] + 1 + i) % N;
      if (m_pend[md][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int md, input logic [2*N-1:0] h, input logic [N-1:0] d);
    bit rel;
    bit to;
    bit np [N];
    int w;
    rel = 1'b0;
    to  = 1'b0;
    if (m_busy[md]) begin
      if (d[m_owner[md]]) rel = 1'b1;
      else if (TMO_EN && (m_wd[md] == TMO - 1)) begin
        rel = 1'b1;
        to  = 1'b1;
      end
    end
    for (int m = 0; m < N; m++) begin
      np[m] = m_pend[md][m];
      if (rel && (m == m_owner[md])) np[m] = 1'b0;
      else if ((h[2*m +: 2] == 2'b10) && !m_pend[md][m]) np[m] = 1'b1;
    end
    if (!m_busy[md]) begin
      w = pick(md);
      if (w >= 0) begin
        m_busy[md]  = 1'b1;
        m_owner[md] = w;
        m_wd[md]    = 0;
      end
    end else if (rel) begin
      m_busy[md]  = 1'b0;
      m_rr[md]    = m_owner[md];
      m_owner[md] = 0;
    end else begin
      m_wd[md]++;
    end
    for (int m = 0; m < N; m++) m_pend[md][m] = np[m];
    m_tmo[md] = to;
  endtask

  task automatic check_model(input int md);
    logic [N-1:0] eh;
    eh = '0;
    if (m_busy[md]) eh[m_owner[md]] = 1'b1;
    chk($sformatf("m%0d_hready", md), hready[md], eh);
    chk($sformatf("m%0d_valid", md), valid[md], m_busy[md]);
    chk($sformatf("m%0d_idx", md), idx[md], m_busy[md] ? m_owner[md] : 0);
    chk($sformatf("m%0d_tmo", md), tmo[md], m_tmo[md]);
    chk($sformatf("m%0d_state", md), dbg[md], m_busy[md]);
  endtask

  // driver: inputs applied at the falling edge, outputs compared at the next falling edge
  task automatic cycle(input logic [2*N-1:0] h0, input logic [N-1:0] d0,
                       input logic [2*N-1:0] h1, input logic [N-1:0] d1);
    htrans[0] = h0;
    done[0]   = d0;
    htrans[1] = h1;
    done[1]   = d1;
    @(posedge HCLK);
    model_step(0, h0, d0);
    model_step(1, h1, d1);
    @(negedge HCLK);
    check_model(0);
    check_model(1);
  endtask

  task automatic do_reset();
    htrans[0] = '0;
    htrans[1] = '0;
    done[0]   = '0;
    done[1]   = '0;
    HRESET    = 1'b1;
    repeat (2) @(negedge HCLK);
    for (int md = 0; md < 2; md++) begin
      chk($sformatf("rst%0d_hready", md), hready[md], 0);
      chk($sformatf("rst%0d_valid", md), valid[md], 0);
      chk($sformatf("rst%0d_idx", md), idx[md], 0);
      chk($sformatf("rst%0d_tmo", md), tmo[md], 0);
    end
    model_reset();
    HRESET = 1'b0;
  endtask

  initial begin
    logic           pv;
    logic [N-1:0]   ack;
    logic [2*N-1:0] rh0, rh1;
    logic [N-1:0]   rd0, rd1;
    int             hi_cnt;
    int             pulses;

    HRESET = 1'b1;
    // fixed-priority instance: {htrans, slave_done, HREADY, grant_valid, grant_idx}
    vecs[0]  = '{6'b001000, 3'b000, 3'b000, 1'b0, 2'd0};
    vecs[1]  = '{6'b000000, 3'b000, 3'b010, 1'b1, 2'd1};
    vecs[2]  = '{6'b000000, 3'b000, 3'b010, 1'b1, 2'd1};
    vecs[3]  = '{6'b000000, 3'b100, 3'b010, 1'b1, 2'd1};
    vecs[4]  = '{6'b000000, 3'b010, 3'b000, 1'b0, 2'd0};
    vecs[5]  = '{6'b000000, 3'b000, 3'b000, 1'b0, 2'd0};
    vecs[6]  = '{6'b000010, 3'b000, 3'b000, 1'b0, 2'd0};
    vecs[7]  = '{6'b000000, 3'b000, 3'b001, 1'b1, 2'd0};
    vecs[8]  = '{6'b000000, 3'b100, 3'b001, 1'b1, 2'd0};
    vecs[9]  = '{6'b000010, 3'b001, 3'b000, 1'b0, 2'd0};
    vecs[10] = '{6'b000000, 3'b000, 3'b000, 1'b0, 2'd0};
    vecs[11] = '{6'b000000, 3'b000, 3'b000, 1'b0, 2'd0};
    vecs[12] = '{6'b001000, 3'b000, 3'b000, 1'b0, 2'd0};
    vecs[13] = '{6'b000010, 3'b000, 3'b010, 1'b1, 2'd1};
    vecs[14] = '{6'b000000, 3'b000, 3'b010, 1'b1, 2'd1};
    vecs[15] = '{6'b000000, 3'b010, 3'b000, 1'b0, 2'd0};
    vecs[16] = '{6'b000000, 3'b000, 3'b001, 1'b1, 2'd0};
    vecs[17] = '{6'b000000, 3'b001, 3'b000, 1'b0, 2'd0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].htr, vecs[i].dn, '0, '0);
      chk($sformatf("vec%0d_hready", i), hready[0], vecs[i].hr);
      chk($sformatf("vec%0d_valid", i), valid[0], vecs[i].v);
      chk($sformatf("vec%0d_idx", i), idx[0], vecs[i].ix);
    end

    // fixed priority: simultaneous requests served 0,1,2 with an idle cycle between grants
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(IW'(i));
    cycle(6'b101010, '0, '0, '0);
    pv = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      ack = valid[0] ? hready[0] : '0;
      cycle('0, ack, '0, '0);
      if (pv) chk("t2_idle_gap", valid[0], 1'b0);
      else if (valid[0]) chk("t2_order", idx[0], exp_q.pop_front());
      pv = valid[0];
    end
    chk("t2_all_granted", exp_q.size(), 0);

    // round-robin: continuous requests from all masters rotate 0,1,2,0,1,2
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(IW'(i % 3));
    pv = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      ack = valid[1] ? hready[1] : '0;
      cycle('0, '0, 6'b101010, ack);
      if (pv) chk("t3_idle_gap", valid[1], 1'b0);
      else if (valid[1]) chk("t3_order", idx[1], exp_q.pop_front());
      pv = valid[1];
    end
    chk("t3_all_granted", exp_q.size(), 0);

    // watchdog: M0 granted and never completed
    do_reset();
    cycle(6'b000010, '0, '0, '0);
`ifdef AHB_ARB_TIMEOUT_EN
    hi_cnt = 0;
    pulses = 0;
    for (int c = 0; c < 3 * TMO; c++) begin
      cycle('0, '0, '0, '0);
      if (hready[0] == 3'b001) hi_cnt++;
      if (tmo[0]) pulses++;
    end
    chk("t5_grant_cycles", hi_cnt, TMO);
    chk("t5_tmo_pulses", pulses, 1);
    chk("t5_released", valid[0], 1'b0);
`else
    hi_cnt = 0;
    pulses = 0;
    for (int c = 0; c < 1000; c++) begin
      cycle('0, '0, '0, '0);
      if (hready[0] == 3'b001) hi_cnt++;
      if (tmo[0]) pulses++;
    end
    chk("t5_held_cycles", hi_cnt, 1000);
    chk("t5_tmo_pulses", pulses, 0);
    chk("t5_held_hready", hready[0], 3'b001);
    cycle('0, 3'b001, '0, '0);
    chk("t5_release", valid[0], 1'b0);
`endif

    // asynchronous reset mid-grant, then a fresh requester must win over the stale one
    do_reset();
    cycle(6'b001010, '0, 6'b001010, '0);
    cycle('0, '0, '0, '0);
    chk("t6_pre_fixed", hready[0], 3'b001);
    chk("t6_pre_rr", hready[1], 3'b001);
    #2 HRESET = 1'b1;
    #1;
    chk("t6_async_hready_fixed", hready[0], 3'b000);
    chk("t6_async_hready_rr", hready[1], 3'b000);
    chk("t6_async_valid_fixed", valid[0], 1'b0);
    chk("t6_async_valid_rr", valid[1], 1'b0);
    model_reset();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    cycle(6'b100000, '0, 6'b100000, '0);
    cycle('0, '0, '0, '0);
    chk("t6_fresh_fixed", idx[0], 2);
    chk("t6_fresh_rr", idx[1], 2);
    chk("t6_fresh_hready", hready[0], 3'b100);

    // random traffic on both instances against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rh0 = 6'($urandom_range(0, 63));
      rh1 = 6'($urandom_range(0, 63));
      rd0 = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      rd1 = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      cycle(rh0, rd0, rh1, rd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
